// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned INST_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction holding register; a flush masks valid in the same cycle.
import fetch_pkg::*;

module fetch_buf #(
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [INST_WIDTH-1:0] i_data,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic                  i_ready,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic                  o_buf_valid,
    output logic [INST_WIDTH-1:0] o_data,
    output logic [PC_WIDTH-1:0]   o_pc
);

    logic                  r_valid;
    logic [INST_WIDTH-1:0] r_data;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  w_pop;

    assign o_valid     = r_valid && !i_flush;
    assign o_buf_valid = r_valid;
    assign o_data      = r_data;
    assign o_pc        = r_pc;
    assign w_pop       = o_valid && i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem request at a time and
// buffers each response for decode, dropping stale responses after a redirect.
import fetch_pkg::*;

module fetch_ctrl #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  INC_AMOUNT   = PC_WIDTH'(4),
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [PC_WIDTH-1:0]   imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [PC_WIDTH-1:0]   inst_pc
);

    fetch_state_e        r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                w_buf_valid;
    logic                w_req_fire;
    logic                w_load;

    // A request may go out only when the buffer is empty or draining this cycle.
    assign imem_req_valid = (r_state == REQ) && !redirect_valid
                            && (!w_buf_valid || inst_ready);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_load         = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;

    fetch_buf #(.PC_WIDTH(PC_WIDTH)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_data      (imem_rsp_data),
        .i_pc        (r_pc),
        .i_ready     (inst_ready),
        .i_flush     (redirect_valid),
        .o_valid     (inst_valid),
        .o_buf_valid (w_buf_valid),
        .o_data      (inst_data),
        .o_pc        (inst_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= RESET_VECTOR;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect_valid) r_pc <= redirect_pc;
                    r_state <= REQ;
                end
                REQ: begin
                    if (redirect_valid) r_pc <= redirect_pc;
                    else if (w_req_fire) r_state <= WAIT;
                end
                WAIT: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_state <= imem_rsp_valid ? REQ : DRAIN;
                    end else if (imem_rsp_valid) begin
                        r_pc    <= r_pc + INC_AMOUNT;
                        r_state <= REQ;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) r_pc <= redirect_pc;
                    if (imem_rsp_valid) r_state <= REQ;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response cut off by reset may still land before the next request; tolerate only that one.
    logic r_stray_ok;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_stray_ok <= 1'b1;
        else if (w_req_fire) r_stray_ok <= 1'b0;
    end

    always @(posedge clk) begin
        if (!rst && !r_stray_ok)
            assert (!(imem_rsp_valid && (r_state == IDLE || r_state == REQ)))
                else $error("imem response with no request outstanding");
    end
`endif

endmodule
